// File: rtl/loader_pkg.sv
// Shared Loader-stage helpers: width derivation and default geometry.
// Blocks derive their own COL_W / CNT_W from their parameters through width_for().
package loader_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_LINE_W = 640;
   localparam int DEF_ROWS   = 3;

   // Per-edge pixel operation; Clear always outranks Enable.
   typedef enum logic [1:0] {
      PIX_HOLD   = 2'd0,
      PIX_ACCEPT = 2'd1,
      PIX_CLEAR  = 2'd2
   } pix_op_e;

   function automatic int width_for(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/line_delay_ram.sv
// One image line of pixel storage, addressed by the shared write column.
// The read is combinational so the tap chain can forward the old word in the writing cycle.
module line_delay_ram #(
   parameter int DATA_W = 8,
   parameter int LINE_W = 640
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [$clog2(LINE_W)-1:0] addr,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [DATA_W-1:0]         rd_data
);

   logic [DATA_W-1:0] mem [LINE_W];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/line_window_buffer.sv
// Multi-row line buffer: per accepted pixel, presents the vertical column of ROWS
// pixels at the same image column, its column index and a full-window Valid flag.
module line_window_buffer
   import loader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LINE_W = DEF_LINE_W,
   parameter int ROWS   = DEF_ROWS
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      Enable,
   input  logic                      Clear,
   input  logic [DATA_W-1:0]         DataIn,
   output logic [ROWS*DATA_W-1:0]    DataOut,
   output logic [$clog2(LINE_W)-1:0] TapCol,
   output logic                      Valid
);

   localparam int COL_W = width_for(LINE_W);
   localparam int CNT_W = width_for(ROWS);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(LINE_W - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ROWS - 1);

   logic [COL_W-1:0]       col_reg;
   logic [COL_W-1:0]       col_next;
   logic [CNT_W-1:0]       line_cnt_reg;
   logic [CNT_W-1:0]       line_cnt_next;
   logic                   col_wrap;
   logic                   accept;
   pix_op_e                pix_op;
   logic [DATA_W-1:0]      tap_word [ROWS];
   logic [ROWS*DATA_W-1:0] data_next;

   always_comb begin
      pix_op = PIX_HOLD;
      if (Clear) begin
         pix_op = PIX_CLEAR;
      end else if (Enable) begin
         pix_op = PIX_ACCEPT;
      end
   end

   assign accept   = (pix_op == PIX_ACCEPT);
   assign col_wrap = (col_reg == LAST_COL);
   assign col_next = col_wrap ? '0 : col_reg + 1'b1;

   always_comb begin
      line_cnt_next = line_cnt_reg;
      if (col_wrap && (line_cnt_reg != FULL_CNT)) begin
         line_cnt_next = line_cnt_reg + 1'b1;
      end
   end

   // Tap 0 is the live pixel; each delay line k stores what tap k-1 held one line earlier.
   assign tap_word[0] = DataIn;

   genvar gi;
   generate
      for (gi = 1; gi < ROWS; gi++) begin : g_delay
         line_delay_ram #(
            .DATA_W (DATA_W),
            .LINE_W (LINE_W)
         ) u_line_delay_ram (
            .clk     (CLK),
            .wr_en   (accept),
            .addr    (col_reg),
            .wr_data (tap_word[gi-1]),
            .rd_data (tap_word[gi])
         );
      end

      for (gi = 0; gi < ROWS; gi++) begin : g_pack
         assign data_next[gi*DATA_W +: DATA_W] = tap_word[gi];
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         col_reg      <= '0;
         line_cnt_reg <= '0;
         DataOut      <= '0;
         TapCol       <= '0;
         Valid        <= 1'b0;
      end else begin
         unique case (pix_op)
            PIX_CLEAR: begin
               col_reg      <= '0;
               line_cnt_reg <= '0;
               Valid        <= 1'b0;
            end
            PIX_ACCEPT: begin
               DataOut      <= data_next;
               TapCol       <= col_reg;
               Valid        <= (line_cnt_reg == FULL_CNT);
               col_reg      <= col_next;
               line_cnt_reg <= line_cnt_next;
            end
            default: begin
               Valid        <= 1'b0;
            end
         endcase
      end
   end

endmodule
